// File: rtl/uart_receiver_if.sv
`default_nettype none
//==============================================================================
// uart_receiver_if : serial line plus received-data/status bundle. Rev 1.0
//==============================================================================
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 recieve_start;
  logic                 recieving;
  logic                 recieve_over;
  logic                 frame_error;

  modport master (
    output rx,
    input  rx_data, recieve_start, recieving, recieve_over, frame_error
  );

  modport slave (
    input  rx,
    output rx_data, recieve_start, recieving, recieve_over, frame_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
//==============================================================================
// uart_receiver : oversampled UART receiver, LSB first, mid-bit sampling. Rev 1.0
//==============================================================================
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  wire logic      s_tick,
  input  wire logic      reset,
  uart_receiver_if.slave bus
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] C_CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state, w_state;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic [IW-1:0]        r_idx, w_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data;
  logic                 r_start, w_start;
  logic                 r_recv, w_recv;
  logic                 r_over, w_over;
  logic                 r_ferr, w_ferr;
  logic                 r_rx_meta, r_rx_s;

  always_ff @(posedge s_tick) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_start   <= 1'b0;
      r_recv    <= 1'b0;
      r_over    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_shift   <= w_shift;
      r_rx_data <= w_rx_data;
      r_start   <= w_start;
      r_recv    <= w_recv;
      r_over    <= w_over;
      r_ferr    <= w_ferr;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_shift   = r_shift;
    w_rx_data = r_rx_data;
    w_start   = 1'b0;
    w_ferr    = 1'b0;
    w_recv    = r_recv;
    w_over    = r_over;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state = S_START;
          w_cnt   = '0;
          w_over  = 1'b0;
        end
      end
      S_START: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == C_CNT_HALF) begin
          w_cnt = '0;
          // A line that is high again at mid start bit was only a glitch.
          if (!r_rx_s) begin
            w_start = 1'b1;
            w_recv  = 1'b1;
            w_idx   = '0;
            w_state = S_DATA;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      S_DATA: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == C_CNT_FULL) begin
          w_cnt   = '0;
          w_shift = {r_rx_s, r_shift[DATA_BITS-1:1]};
          w_idx   = r_idx + IW'(1);
          if (r_idx == C_IDX_LAST) begin
            w_rx_data = w_shift;
            w_recv    = 1'b0;
            w_state   = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == C_CNT_FULL) begin
          w_cnt = '0;
          if (r_rx_s) begin
            w_over  = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.rx_data       = r_rx_data;
  assign bus.recieve_start = r_start;
  assign bus.recieving     = r_recv;
  assign bus.recieve_over  = r_over;
  assign bus.frame_error   = r_ferr;
endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
//==============================================================================
// tb_uart_receiver : scoreboard bench for uart_receiver. Rev 1.0
//==============================================================================
module tb_uart_receiver;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int N_RAND = 150;

  logic s_tick = 1'b0;
  logic reset  = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_over_rise = 0;
  int n_ferr = 0;
  int recv_cycles = 0;
  int s0, o0, f0, c0;
  logic prev_over = 1'b0;
  logic [DB-1:0] rb;
  logic [DB-1:0] c3;

  typedef struct {
    logic [DB-1:0] data;
    logic          ferr;
  } exp_t;

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    logic [DB-1:0] exp_data;
    logic          exp_ferr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  uart_receiver_if #(.DATA_BITS(DB)) u_if ();

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .s_tick (s_tick),
    .reset  (reset),
    .bus    (u_if.slave)
  );

  always #5 s_tick = ~s_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input logic ferr);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: frame end (ferr=%0b, data=0x%0h), expected none", ferr, u_if.rx_data);
    end else begin
      e = sb.pop_front();
      chk("sb_data", 32'(u_if.rx_data), 32'(e.data));
      chk("sb_ferr", 32'(ferr), 32'(e.ferr));
    end
  endtask

  always @(negedge s_tick) begin
    if (reset) begin
      prev_over = 1'b0;
    end else begin
      if (u_if.recieve_start) n_start++;
      if (u_if.recieving) recv_cycles++;
      if (u_if.frame_error) begin
        n_ferr++;
        score(1'b1);
      end
      if (u_if.recieve_over && !prev_over) begin
        n_over_rise++;
        score(1'b0);
      end
      prev_over = u_if.recieve_over;
    end
  end

  task automatic hold(input logic v, input int n);
    u_if.rx = v;
    repeat (n) @(negedge s_tick);
  endtask

  task automatic send(input logic [DB-1:0] d, input logic stop);
    hold(1'b0, OS);
    for (int i = 0; i < DB; i++) hold(d[i], OS);
    hold(stop, OS);
  endtask

  task automatic expect_frame(input logic [DB-1:0] d, input logic ferr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge s_tick);
      k++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_data"}, 32'(u_if.rx_data), 32'd0);
    chk({tag, "_start"},   32'(u_if.recieve_start), 32'd0);
    chk({tag, "_recv"},    32'(u_if.recieving), 32'd0);
    chk({tag, "_over"},    32'(u_if.recieve_over), 32'd0);
    chk({tag, "_ferr"},    32'(u_if.frame_error), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    tbl[1] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    tbl[2] = '{data: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
    tbl[3] = '{data: 8'h01, stop: 1'b1, exp_data: 8'h01, exp_ferr: 1'b0};
    tbl[4] = '{data: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_ferr: 1'b0};
    tbl[5] = '{data: 8'h7E, stop: 1'b1, exp_data: 8'h7E, exp_ferr: 1'b0};

    u_if.rx = 1'b1;
    reset   = 1'b1;
    repeat (4) @(negedge s_tick);
    chk_all_zero("reset");
    reset = 1'b0;
    hold(1'b1, 20);

    // Single valid frame 0xA5
    s0 = n_start; c0 = recv_cycles; o0 = n_over_rise;
    expect_frame(8'hA5, 1'b0);
    send(8'hA5, 1'b1);
    hold(1'b1, 50);
    drain(100);
    chk("a5_start_pulses", 32'(n_start - s0), 32'd1);
    chk("a5_recv_cycles", 32'(recv_cycles - c0), 32'(DB * OS));
    chk("a5_over_rises", 32'(n_over_rise - o0), 32'd1);
    chk("a5_over_held", 32'(u_if.recieve_over), 32'd1);
    chk("a5_rx_data", 32'(u_if.rx_data), 32'hA5);

    // Short low glitch on an idle line
    s0 = n_start; c0 = recv_cycles;
    hold(1'b0, 5);
    hold(1'b1, 40);
    chk("glitch_start", 32'(n_start - s0), 32'd0);
    chk("glitch_recv", 32'(recv_cycles - c0), 32'd0);
    chk("glitch_rx_data", 32'(u_if.rx_data), 32'hA5);
    chk("glitch_over_cleared", 32'(u_if.recieve_over), 32'd0);

    // Framing error, break, then recovery
    s0 = n_start; f0 = n_ferr;
    expect_frame(8'h3C, 1'b1);
    send(8'h3C, 1'b0);
    hold(1'b0, 40);
    chk("break_over", 32'(u_if.recieve_over), 32'd0);
    chk("break_rx_data", 32'(u_if.rx_data), 32'h3C);
    hold(1'b1, 32);
    expect_frame(8'h81, 1'b0);
    send(8'h81, 1'b1);
    hold(1'b1, 20);
    drain(100);
    chk("break_ferr_pulses", 32'(n_ferr - f0), 32'd1);
    chk("break_start_pulses", 32'(n_start - s0), 32'd2);
    chk("break_rx_data_81", 32'(u_if.rx_data), 32'h81);

    // Back-to-back frames from the table
    s0 = n_start; o0 = n_over_rise;
    for (int i = 0; i < 6; i++) begin
      expect_frame(tbl[i].exp_data, tbl[i].exp_ferr);
      send(tbl[i].data, tbl[i].stop);
    end
    hold(1'b1, 20);
    drain(100);
    chk("b2b_start_pulses", 32'(n_start - s0), 32'd6);
    chk("b2b_over_rises", 32'(n_over_rise - o0), 32'd6);

    // Reset in the middle of bit 4 of 0xC3
    c3 = 8'hC3;
    hold(1'b0, OS);
    for (int i = 0; i < 4; i++) hold(c3[i], OS);
    hold(c3[4], OS / 2);
    reset = 1'b1;
    @(negedge s_tick);
    chk_all_zero("midreset");
    hold(1'b1, 2);
    reset = 1'b0;
    hold(1'b1, 40);
    chk("postreset_rx_data", 32'(u_if.rx_data), 32'd0);
    expect_frame(8'h12, 1'b0);
    send(8'h12, 1'b1);
    hold(1'b1, 20);
    drain(100);
    chk("postreset_rx_data_12", 32'(u_if.rx_data), 32'h12);

    // Random back-to-back stream
    o0 = n_over_rise;
    for (int i = 0; i < N_RAND; i++) begin
      rb = DB'($urandom_range(0, (1 << DB) - 1));
      expect_frame(rb, 1'b0);
      send(rb, 1'b1);
    end
    hold(1'b1, 20);
    drain(200);
    chk("rand_over_rises", 32'(n_over_rise - o0), 32'(N_RAND));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
